keypad_scanner: RTL and testbench

- Scans a 4x4 matrix keypad and debounces it, producing a hex key code for the board's 7-segment display path.
- It is the input-side counterpart of the display path: the display path drives segments and anodes, while this block drives keypad rows and reads keypad columns.
- Its output (key_code, key_valid) replaces raw switch values as the source of displayed digits.

---
 rtl/keypad_pkg.sv | 18 +
 rtl/scan_tick_gen.sv | 21 ++
 rtl/keypad_scanner.sv | 138 +++++++++++++
 tb/tb_keypad_scanner.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;
    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam logic [NUM_COLS-1:0] COL_IDLE = 4'b1111;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD} state_t;

    // Lowest-index low column wins when several keys share a row.
    function automatic logic [1:0] col_prio(input logic [NUM_COLS-1:0] c);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_COLS - 1; i >= 0; i--) begin
            if (!c[i]) idx = i[1:0];
        end
        return idx;
    endfunction
endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider producing a one-cycle tick every SCAN_DIV clocks.
module scan_tick_gen #(
    parameter int SCAN_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)              cnt <= '0;
        else if (cnt == LAST) cnt <= '0;
        else                  cnt <= cnt + CW'(1);
    end

    assign tick = (cnt == LAST);
endmodule

// File: rtl/keypad_scanner.sv
// Row-scanning, debounced 4x4 keypad reader producing a hex key code.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_pressed
);
    localparam int MW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [MW-1:0] MATCH_DONE = MW'(DEBOUNCE_SCANS);

    logic [3:0]    col_p0, col_p1, col_s;
    logic          tick;
    state_t        state, state_n;
    logic [1:0]    row_idx, row_idx_n;
    logic [3:0]    cand, cand_n;
    logic [MW-1:0] match_cnt, match_n, match_inc;
    logic [3:0]    key_code_n;
    logic          key_valid_n, key_pressed_n;
    logic          any_low;
    logic [1:0]    col_idx;

    // Stage p0/p1: two-flop synchronizer for the asynchronous column lines
    always_ff @(posedge clk) begin
        if (rst) begin
            col_p0 <= COL_IDLE;
            col_p1 <= COL_IDLE;
        end else begin
            col_p0 <= col;
            col_p1 <= col_p0;
        end
    end
    assign col_s = col_p1;

    scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign any_low   = (col_s != COL_IDLE);
    assign col_idx   = col_prio(col_s);
    assign match_inc = match_cnt + MW'(1);
    assign row       = ~(4'b0001 << row_idx);

    always_comb begin
        state_n       = state;
        row_idx_n     = row_idx;
        cand_n        = cand;
        match_n       = match_cnt;
        key_code_n    = key_code;
        key_valid_n   = 1'b0;
        key_pressed_n = key_pressed;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (any_low) begin
                        cand_n = {row_idx, col_idx};
                        if (MW'(1) == MATCH_DONE) begin
                            key_code_n    = {row_idx, col_idx};
                            key_valid_n   = 1'b1;
                            key_pressed_n = 1'b1;
                            match_n       = '0;
                            state_n       = HOLD;
                        end else begin
                            match_n = MW'(1);
                            state_n = DEBOUNCE;
                        end
                    end else begin
                        row_idx_n = row_idx + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (any_low && (col_idx == cand[1:0])) begin
                        if (match_inc == MATCH_DONE) begin
                            key_code_n    = cand;
                            key_valid_n   = 1'b1;
                            key_pressed_n = 1'b1;
                            match_n       = '0;
                            state_n       = HOLD;
                        end else begin
                            match_n = match_inc;
                        end
                    end else begin
                        match_n   = '0;
                        row_idx_n = row_idx + 2'd1;
                        state_n   = SCAN;
                    end
                end
                HOLD: begin
                    // Same counter doubles as the release debouncer while held.
                    if (!any_low) begin
                        if (match_inc == MATCH_DONE) begin
                            key_pressed_n = 1'b0;
                            match_n       = '0;
                            row_idx_n     = row_idx + 2'd1;
                            state_n       = SCAN;
                        end else begin
                            match_n = match_inc;
                        end
                    end else begin
                        match_n = '0;
                    end
                end
                default: state_n = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SCAN;
            row_idx     <= '0;
            match_cnt   <= '0;
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_pressed <= 1'b0;
        end else begin
            state       <= state_n;
            row_idx     <= row_idx_n;
            match_cnt   <= match_n;
            key_code    <= key_code_n;
            key_valid   <= key_valid_n;
            key_pressed <= key_pressed_n;
        end
    end

    always_ff @(posedge clk) begin
        cand <= cand_n;
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural keypad and key-code scoreboard.
module tb_keypad_scanner;
    localparam int SD = 4;
    localparam int DS = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] keys, keys1;
    logic [3:0]  col, row, key_code;
    logic        key_valid, key_pressed;
    logic [3:0]  col1, row1, code1;
    logic        valid1, pressed1;

    logic [3:0] sb0[$];
    logic [3:0] sb1[$];
    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [3:0] pad(input logic [3:0] r, input logic [15:0] k);
        logic [3:0] c;
        c = 4'b1111;
        for (int ri = 0; ri < 4; ri++)
            if (!r[ri])
                for (int ci = 0; ci < 4; ci++)
                    if (k[ri*4+ci]) c[ci] = 1'b0;
        return c;
    endfunction

    assign col  = pad(row, keys);
    assign col1 = pad(row1, keys1);

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
        .clk(clk), .rst(rst), .col(col), .row(row),
        .key_code(key_code), .key_valid(key_valid), .key_pressed(key_pressed)
    );

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(1)) dut1 (
        .clk(clk), .rst(rst), .col(col1), .row(row1),
        .key_code(code1), .key_valid(valid1), .key_pressed(pressed1)
    );

    // Every key_valid must match the next expected code; 5'h10 marks "none expected".
    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            logic [4:0] e;
            if (sb0.size() > 0) e = {1'b0, sb0.pop_front()};
            else                e = 5'h10;
            n_assert++;
            assert ({1'b0, key_code} === e) else begin
                n_fail++;
                $error("FAIL valid_code observed=%0h expected=%0h", key_code, e);
            end
        end
        if (valid1 === 1'b1) begin
            logic [4:0] e1;
            if (sb1.size() > 0) e1 = {1'b0, sb1.pop_front()};
            else                e1 = 5'h10;
            n_assert++;
            assert ({1'b0, code1} === e1) else begin
                n_fail++;
                $error("FAIL valid1_code observed=%0h expected=%0h", code1, e1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_row(input bit sel, input logic [3:0] target, input int maxc, output bit ok);
        int i;
        ok = 1'b0;
        for (i = 0; i < maxc; i++) begin
            step();
            if ((sel ? row1 : row) != target) break;
        end
        for (; i < maxc; i++) begin
            step();
            if ((sel ? row1 : row) == target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_sb(input bit sel, input int maxc, output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        for (int i = 1; i <= maxc; i++) begin
            step();
            if ((sel ? sb1.size() : sb0.size()) == 0) begin
                ok = 1'b1;
                n  = i;
                break;
            end
        end
    endtask

    task automatic wait_fall(input bit sel, input int maxc, output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        for (int i = 1; i <= maxc; i++) begin
            step();
            if ((sel ? pressed1 : key_pressed) == 1'b0) begin
                ok = 1'b1;
                n  = i;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        int n;
        logic [3:0] er;

        rst = 1'b1; keys = '0; keys1 = '0;
        repeat (3) step();
        chk("rst_row", row, 4'b1110);
        chk("rst_code", key_code, 4'h0);
        chk("rst_valid", key_valid, 1'b0);
        chk("rst_pressed", key_pressed, 1'b0);
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            er = ~(4'b0001 << ((k / SD) % 4));
            chk("scan_row", row, er);
        end

        // Clean press of key 9 (row 2, col 1)
        keys[9] = 1'b1; sb0.push_back(4'h9);
        wait_sb(0, 40, n, ok);
        chk("press9_timeout", ok, 1'b1);
        chk("press9_latency", (n <= (4 + DS) * SD + 4), 1'b1);
        chk("press9_code", key_code, 4'h9);
        chk("press9_pressed", key_pressed, 1'b1);
        chk("press9_row", row, 4'b1011);
        repeat (12) step();
        chk("hold9_row", row, 4'b1011);
        chk("hold9_pressed", key_pressed, 1'b1);

        keys[9] = 1'b0;
        wait_fall(0, 40, n, ok);
        chk("rel9_timeout", ok, 1'b1);
        chk("rel9_latency", (n >= 2 * SD + 1) && (n <= (DS + 1) * SD + 3), 1'b1);
        chk("rel9_row", row, 4'b0111);
        chk("rel9_code", key_code, 4'h9);

        // Bounce on key 3 (row 0, col 3): 1 tick on, 1 tick off, then held
        wait_row(0, 4'b1110, 40, ok);
        chk("bounce_sync", ok, 1'b1);
        keys[3] = 1'b1; repeat (SD) step();
        keys[3] = 1'b0; repeat (SD) step();
        keys[3] = 1'b1; sb0.push_back(4'h3);
        wait_sb(0, 80, n, ok);
        chk("bounce_timeout", ok, 1'b1);
        chk("bounce_code", key_code, 4'h3);
        keys[3] = 1'b0;
        wait_fall(0, 40, n, ok);
        chk("rel3_timeout", ok, 1'b1);

        // Two keys in row 1 resolve to col 0; key F is locked out while held
        keys[4] = 1'b1; keys[6] = 1'b1; sb0.push_back(4'h4);
        wait_sb(0, 60, n, ok);
        chk("multi_timeout", ok, 1'b1);
        chk("multi_code", key_code, 4'h4);
        keys[15] = 1'b1;
        repeat (30) step();
        chk("lock_pressed", key_pressed, 1'b1);
        chk("lock_row", row, 4'b1101);
        chk("lock_code", key_code, 4'h4);
        sb0.push_back(4'hF);
        keys[4] = 1'b0; keys[6] = 1'b0;
        wait_sb(0, 100, n, ok);
        chk("keyF_timeout", ok, 1'b1);
        chk("keyF_code", key_code, 4'hF);
        keys[15] = 1'b0;
        wait_fall(0, 40, n, ok);
        chk("relF_timeout", ok, 1'b1);

        // Reset after two matching debounce ticks on key 0
        wait_row(0, 4'b1110, 40, ok);
        chk("rstdb_sync", ok, 1'b1);
        keys[0] = 1'b1;
        repeat (2 * SD) step();
        chk("rstdb_row_held", row, 4'b1110);
        chk("rstdb_no_press", key_pressed, 1'b0);
        rst = 1'b1;
        step();
        chk("rstdb_row", row, 4'b1110);
        chk("rstdb_code", key_code, 4'h0);
        chk("rstdb_valid", key_valid, 1'b0);
        chk("rstdb_pressed", key_pressed, 1'b0);
        rst = 1'b0; keys[0] = 1'b0;
        repeat (40) step();
        chk("rstdb_idle_code", key_code, 4'h0);

        // Single-scan debounce: key 2 accepted on its first sampling tick
        wait_row(1, 4'b1110, 40, ok);
        chk("ds1_sync", ok, 1'b1);
        keys1[2] = 1'b1; sb1.push_back(4'h2);
        wait_sb(1, 20, n, ok);
        chk("ds1_timeout", ok, 1'b1);
        chk("ds1_latency", (n <= SD + 4), 1'b1);
        chk("ds1_code", code1, 4'h2);
        chk("ds1_pressed", pressed1, 1'b1);
        keys1[2] = 1'b0;
        wait_fall(1, 20, n, ok);
        chk("ds1_rel_timeout", ok, 1'b1);
        chk("ds1_rel_latency", (n <= 2 * SD + 3), 1'b1);

        chk("sb_drained", sb0.size() + sb1.size(), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
